// File: rtl/cmp_unit_iter_pkg.sv
// Shared CMPOP opcode / CMPI state macros plus the iterative comparator package.
// Optional build macro: CMP_EARLY_EXIT_EN (data-dependent early exit in BUSY).
`ifndef CMP_UNIT_VH
`define CMP_UNIT_VH
`define CMPOP_WIDTH 3
`define CMPOP_BEQ   3'd0
`define CMPOP_BNE   3'd1
`define CMPOP_BLT   3'd4
`define CMPOP_BGE   3'd5
`define CMPOP_BLTU  3'd6
`define CMPOP_BGEU  3'd7
`define CMPI_ST_IDLE 2'd0
`define CMPI_ST_BUSY 2'd1
`define CMPI_ST_DONE 2'd2
`endif

package cmp_unit_iter_pkg;
  localparam logic [1:0] ST_IDLE = `CMPI_ST_IDLE;
  localparam logic [1:0] ST_BUSY = `CMPI_ST_BUSY;
  localparam logic [1:0] ST_DONE = `CMPI_ST_DONE;

  typedef logic [`CMPOP_WIDTH-1:0] cmpop_t;

  function automatic logic is_signed_op(input cmpop_t op);
    return (op == `CMPOP_BLT) || (op == `CMPOP_BGE);
  endfunction

  function automatic logic cmp_map(input cmpop_t op, input logic eq, input logic lt);
    logic r;
    case (op)
      `CMPOP_BEQ:               r = eq;
      `CMPOP_BNE:               r = !eq;
      `CMPOP_BLT,  `CMPOP_BLTU: r = lt;
      `CMPOP_BGE,  `CMPOP_BGEU: r = !lt;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/cmp_unit_iter_chunk.sv
// Combinational CHUNK-bit unsigned compare: equality and less-than.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);
  assign eq = (a == b);
  assign lt = (a < b);
endmodule

// File: rtl/cmp_unit_iter.sv
// Iterative branch comparator, MS chunk first, valid/ready on both sides.
// Build macro CMP_EARLY_EXIT_EN: stop at first differing chunk; otherwise constant N cycles.
module cmp_unit_iter
  import cmp_unit_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [`CMPOP_WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0]        i_a,
  input  logic [WIDTH-1:0]        i_b,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic                    o_out
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  logic [1:0]       state;
  cmpop_t           op_r;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             eq_r, lt_r, decided;
  logic             ch_eq, ch_lt;
  logic             fin_eq, fin_lt, last, finish;
  logic [WIDTH-1:0] flip;

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_sh[WIDTH-1 -: CHUNK]),
    .b  (b_sh[WIDTH-1 -: CHUNK]),
    .eq (ch_eq),
    .lt (ch_lt)
  );

  // Once a difference is latched, later chunks no longer influence the result.
  assign fin_eq = decided ? eq_r : ch_eq;
  assign fin_lt = decided ? lt_r : ch_lt;
  assign last   = (cnt == CW'(N - 1));
`ifdef CMP_EARLY_EXIT_EN
  assign finish = last || !ch_eq;
`else
  assign finish = last;
`endif

  // Biasing the sign bit turns a signed compare into an unsigned one.
  assign flip    = is_signed_op(i_op) ? MSB : '0;
  assign i_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_r    <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      eq_r    <= 1'b0;
      lt_r    <= 1'b0;
      decided <= 1'b0;
      o_out   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            op_r    <= i_op;
            a_sh    <= i_a ^ flip;
            b_sh    <= i_b ^ flip;
            cnt     <= '0;
            eq_r    <= 1'b0;
            lt_r    <= 1'b0;
            decided <= 1'b0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_sh <= a_sh << CHUNK;
          b_sh <= b_sh << CHUNK;
          cnt  <= cnt + CW'(1);
          if (!decided && !ch_eq) begin
            decided <= 1'b1;
            eq_r    <= 1'b0;
            lt_r    <= ch_lt;
          end
          if (finish) begin
            eq_r  <= fin_eq;
            lt_r  <= fin_eq ? 1'b0 : fin_lt;
            o_out <= cmp_map(op_r, fin_eq, fin_eq ? 1'b0 : fin_lt);
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (o_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_unit_iter.sv
// Directed table-driven bench for cmp_unit_iter (WIDTH=32, CHUNK=8).
module tb_cmp_unit_iter;
  localparam logic [2:0] BEQ = 3'd0, BNE = 3'd1, BLT = 3'd4, BGE = 3'd5,
                         BLTU = 3'd6, BGEU = 3'd7, BAD = 3'd2;

  logic        clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, o_ready = 1'b1;
  logic [2:0]  i_op = '0;
  logic [31:0] i_a = '0, i_b = '0;
  logic        i_ready, o_valid, o_out;
  int          pass_cnt = 0, tot_cnt = 0;

  cmp_unit_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int model_k(input logic [31:0] a, input logic [31:0] b);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 0; i < 4; i++)
      if (a[31-8*i -: 8] != b[31-8*i -: 8]) return i + 1;
`endif
    return 4;
  endfunction

  // Issue one request, return the number of edges after acceptance until o_valid.
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int lat, output logic res);
    @(negedge clk);
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o_out;
  endtask

  vec_t vecs [11];
  int   lat, vcnt;
  logic res;

  initial begin
    vecs[0]  = '{BEQ,  32'h12345678, 32'h12345678, 1'b1};
    vecs[1]  = '{BNE,  32'h12345678, 32'h12345678, 1'b0};
    vecs[2]  = '{BLTU, 32'h80000000, 32'h7FFFFFFF, 1'b0};
    vecs[3]  = '{BLT,  32'h80000000, 32'h7FFFFFFF, 1'b1};
    vecs[4]  = '{BGE,  32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[5]  = '{BGEU, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[6]  = '{BLT,  32'h000000FE, 32'h000000FF, 1'b1};
    vecs[7]  = '{BLTU, 32'h01000000, 32'h02000000, 1'b1};
    vecs[8]  = '{BAD,  32'h00000001, 32'h00000002, 1'b0};
    vecs[9]  = '{BNE,  32'h00000005, 32'h00000006, 1'b1};
    vecs[10] = '{BGE,  32'h00000003, 32'hFFFFFFFD, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ready", {31'b0, i_ready}, 1);
    chk("rst_o_valid", {31'b0, o_valid}, 0);
    chk("rst_o_out",   {31'b0, o_out},   0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
      chk($sformatf("v%0d_latency", i), lat, model_k(vecs[i].a, vecs[i].b));
      chk($sformatf("v%0d_out", i), {31'b0, res}, {31'b0, vecs[i].exp});
      @(posedge clk); #1;
      chk($sformatf("v%0d_back_idle", i), {31'b0, i_ready}, 1);
    end

    // Backpressure in DONE
    o_ready = 1'b0;
    run(BEQ, 32'hCAFEF00D, 32'hCAFEF00D, lat, res);
    chk("bp_latency", lat, 4);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_o_valid", c), {31'b0, o_valid}, 1);
      chk($sformatf("bp%0d_o_out", c),   {31'b0, o_out},   1);
      chk($sformatf("bp%0d_i_ready", c), {31'b0, i_ready}, 0);
      @(posedge clk); #1;
    end
    @(negedge clk) o_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_i_ready", {31'b0, i_ready}, 1);
    chk("bp_release_o_valid", {31'b0, o_valid}, 0);
    run(BLTU, 32'h00000010, 32'h00000020, lat, res);
    chk("bp_next_out", {31'b0, res}, 1);
    @(posedge clk); #1;

    // Reset during the second BUSY cycle
    @(negedge clk);
    i_op = BEQ; i_a = 32'h0; i_b = 32'h0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_i_ready", {31'b0, i_ready}, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_i_ready", {31'b0, i_ready}, 1);
    chk("mid_rst_o_valid", {31'b0, o_valid}, 0);
    chk("mid_rst_o_out",   {31'b0, o_out},   0);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_valid) vcnt++;
    end
    chk("no_spurious_valid", vcnt, 0);
    run(BGEU, 32'h00000001, 32'h00000002, lat, res);
    chk("post_rst_out", {31'b0, res}, 0);
    chk("post_rst_latency", lat, 4);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
